// File: rtl/mem_line_scan.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_scan
// Brief    : Takes over the data-memory address path to walk word lines
//            0..LINES-1, capturing and presenting each word for HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_line_scan #(
    parameter int LINES  = 16,
    parameter int RD_LAT = 1,
    parameter int HOLD   = 4,
    parameter int HOLD_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [2:0]  cpu_mode,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  mode_out,
    output logic [3:0]  line_num,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0]        c_SCAN_MODE = 3'b100;
    localparam logic [2:0]        c_LAT_LAST  = 3'(RD_LAT);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [3:0]        c_LINE_LAST = 4'(LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_lat;
    logic [HOLD_W-1:0]  r_hold;
    logic [3:0]         r_line;
    logic [31:0]        r_disp;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lat   <= 3'd0;
            r_hold  <= '0;
            r_line  <= 4'd0;
            r_disp  <= 32'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            // stop beats every state transition; captured data is kept
            if (stop && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            r_state <= S_ADDR;
                            r_line  <= 4'd0;
                            r_lat   <= 3'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (r_lat == c_LAT_LAST) begin
                            r_disp  <= mem_rdata;
                            r_valid <= 1'b1;
                            r_hold  <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_lat <= r_lat + 3'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold == c_HOLD_LAST) begin
                            if (r_line != c_LINE_LAST) begin
                                r_line  <= r_line + 4'd1;
                                r_lat   <= 3'd0;
                                r_state <= S_ADDR;
                            end else if (loop) begin
                                r_line  <= 4'd0;
                                r_lat   <= 3'd0;
                                r_state <= S_ADDR;
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // busy is registered from the state, so the mux switch is glitch-free
    assign mode_out   = r_busy ? c_SCAN_MODE : cpu_mode;
    assign line_num   = r_line;
    assign disp_data  = r_disp;
    assign disp_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/mem_line_scan.md
Name: mem_line_scan

Overview:
- Sequencer directly upstream of the data-memory address mux.
- On request, it takes over the memory address path and walks the word lines 0..LINES-1. It drives `line_num` together with the line-select mode code 3'b100, captures each word read back, and holds it on a display register for a programmable time.
- When idle it passes the CPU's mode code through unchanged, so normal ALU-addressed accesses are unaffected.

Parameters:
- LINES, 16: number of word lines scanned, 2..16; `line_num` counts 0..LINES-1.
- RD_LAT, 1: memory read latency in cycles, 0..7. `line_num` is held RD_LAT+1 cycles before sampling.
- HOLD, 4: cycles each captured word is presented, 1..2^HOLD_W-1.
- HOLD_W, 26: width of the hold counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level or pulse; begins a scan when sampled high in IDLE.
- stop  in  1  aborts a scan; priority over everything except rst.
- loop  in  1  when 1, the scan wraps from line LINES-1 back to 0 instead of finishing.
- cpu_mode  in  3  mode code from the control unit.
- mem_rdata  in  32  read data from data memory.
- mode_out  out  3  mode code to the address mux: 3'b100 while busy, else cpu_mode (combinational).
- line_num  out  4  line index to the address mux (registered).
- disp_data  out  32  last captured memory word (registered).
- disp_valid  out  1  one-cycle pulse when disp_data updates.
- busy  out  1  high in ADDR and HOLD.
- done  out  1  one-cycle pulse on scan completion.

Behaviour:
- Reset (rst high at an edge): state IDLE; line_num=0, disp_data=0, disp_valid=0, busy=0, done=0; all counters cleared. rst mid-scan aborts immediately; the next cycle mode_out=cpu_mode.
- States: IDLE, ADDR, HOLD, DONE. The state register is one-hot or binary (implementer's choice); unreachable encodings go to IDLE.
- IDLE:
  - busy=0, mode_out=cpu_mode.
  - start=1 at an edge -> ADDR with line_num=0 and the latency counter cleared.
- ADDR:
  - busy=1, mode_out=3'b100, line_num stable.
  - Lasts exactly RD_LAT+1 cycles.
  - At the edge ending the last ADDR cycle: disp_data<=mem_rdata, disp_valid<=1, then -> HOLD with the hold counter cleared.
- HOLD:
  - busy=1, mode_out=3'b100.
  - disp_valid is high only in the first HOLD cycle.
  - Lasts exactly HOLD cycles. At the end:
    - line_num<LINES-1 -> line_num+1, then ADDR.
    - line_num==LINES-1 and loop=1 -> line_num=0, then ADDR.
    - line_num==LINES-1 and loop=0 -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE. line_num stays at LINES-1 until the next start.
- Per-line period: RD_LAT+1+HOLD cycles. Full scan: start edge plus LINES×period cycles, then 1 DONE cycle.
- stop=1 at an edge while in ADDR/HOLD/DONE:
  - -> IDLE next cycle.
  - disp_data retained; done not pulsed; disp_valid forced 0.
- stop and start both high in IDLE: stay in IDLE.
- start while busy: ignored; no restart.
- loop is sampled only at the end of the last line's HOLD. Deasserting it mid-scan finishes the current pass normally.
- line_num never exceeds LINES-1, and its upper bits are 0 when LINES<16.
- disp_data changes only on a capture edge or on rst.

Test Plan:
All scenarios use LINES=4, RD_LAT=1, HOLD=3. Memory word n = 32'hA000_0000+n with 1-cycle registered read. Cycle 0 is the cycle in which start is sampled.
1. Single scan:
   - mode_out=3'b100 and busy=1 in cycles 1..20.
   - line_num=n in cycles 1+5n..5+5n.
   - disp_valid in cycles 3,8,13,18 with disp_data=A0000000..A0000003.
   - done=1 in cycle 21; busy=0 and mode_out=cpu_mode (drive 3'b010) in cycle 21 onward.
2. Idle pass-through: cpu_mode swept 0..7 with start=0 -> mode_out tracks it in the same cycle; line_num=0, disp_valid never high.
3. Loop: loop=1 throughout -> line_num sequence 0,1,2,3,0,1 with no done pulse. loop dropped during the second pass -> done exactly once, after line 3 of that pass.
4. Abort: stop=1 in cycle 9 -> IDLE in cycle 10; disp_data=A0000001 retained; no done pulse. A new start then restarts at line 0.
5. Reset mid-scan: rst in cycle 7 -> cycle 8 has busy=0, line_num=0, disp_data=0, mode_out=cpu_mode.
6. start held high through a scan and after it -> no restart while busy; a new scan begins with IDLE sampling start in cycle 22.
